// File: rtl/frame_pkg.sv
// Constants shared by the line framer and frame receiver: magic preamble,
// receiver state encoding and default payload length.
package frame_pkg;

  localparam int MAGIC_LENGTH = 6;
  localparam logic [7:0] MAGIC_HEAD = 8'hF6;
  localparam logic [7:0] MAGIC_TAIL = 8'h28;
  localparam logic [8*MAGIC_LENGTH-1:0] MAGIC_SEQ = {{3{MAGIC_HEAD}}, {3{MAGIC_TAIL}}};

  localparam int FRAME_LENGTH_DEFAULT = 16;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_CAPTURE = 1'b1
  } rx_state_t;

endpackage

// File: rtl/frame_magic_detect.sv
// Preamble comparator: five bytes of history plus the live rxd byte form the
// 6-byte window, so match pulses on the edge that samples the final 0x28.
module frame_magic_detect
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rxd,
  output logic       match
);

  localparam int HIST_W = 8 * (MAGIC_LENGTH - 1);

  logic [HIST_W-1:0] hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= {hist_reg[HIST_W-9:0], rxd};
    end
  end

  assign match = ({hist_reg, rxd} == MAGIC_SEQ);

endmodule

// File: rtl/frame_receiver.sv
// Receive framer: hunts for the magic preamble, captures FRAME_LENGTH payload
// bytes and serves them as 16-bit words. Define FRAME_RX_STATS_EN for counters.
module frame_receiver
  import frame_pkg::*;
#(
  parameter int FRAME_LENGTH = FRAME_LENGTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        hunting,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data
`ifdef FRAME_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] overrun_cnt
`endif
);

  localparam int WORDS = FRAME_LENGTH / 2;
  localparam int WA = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LENGTH - 1);
  localparam logic [2:0] FRESH_FULL = 3'(MAGIC_LENGTH - 1);

  logic       match;
  logic       match_ok;
  logic       capture_done;
  rx_state_t  state_reg, state_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic [2:0] fresh_reg, fresh_next;
  logic       frame_valid_reg, frame_valid_next;

  frame_magic_detect u_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .match (match)
  );

  // fresh_reg counts post-capture bytes in the window, so payload tail bytes
  // can never combine with new bytes into a false preamble.
  assign match_ok     = match && (fresh_reg == FRESH_FULL);
  assign capture_done = (state_reg == ST_CAPTURE) && (byte_cnt_reg == LAST_BYTE);

  always_comb begin
    state_next       = state_reg;
    byte_cnt_next    = byte_cnt_reg;
    fresh_next       = fresh_reg;
    frame_valid_next = frame_valid_reg && !frame_ack;
    case (state_reg)
      ST_HUNT: begin
        if (fresh_reg != FRESH_FULL) begin
          fresh_next = fresh_reg + 3'd1;
        end
        if (match_ok && (!frame_valid_reg || frame_ack)) begin
          state_next    = ST_CAPTURE;
          byte_cnt_next = '0;
        end
      end
      ST_CAPTURE: begin
        byte_cnt_next = byte_cnt_reg + 8'd1;
        fresh_next    = '0;
        if (capture_done) begin
          frame_valid_next = 1'b1;
          state_next       = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_HUNT;
      byte_cnt_reg    <= '0;
      fresh_reg       <= FRESH_FULL;
      frame_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      byte_cnt_reg    <= byte_cnt_next;
      fresh_reg       <= fresh_next;
      frame_valid_reg <= frame_valid_next;
    end
  end

  assign frame_valid = frame_valid_reg;
  assign hunting     = (state_reg == ST_HUNT);

  // Buffer split into even (high) and odd (low) byte lanes, one word per address.
  logic          wr_en;
  logic          rd_oob;
  logic [WA-1:0] wr_word;
  logic [WA-1:0] rd_word;

  assign wr_en   = (state_reg == ST_CAPTURE);
  assign wr_word = byte_cnt_reg[WA:1];
  assign rd_word = rd_addr[WA-1:0];
  assign rd_oob  = (rd_addr >= 8'(WORDS));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : lane_g
      logic [7:0] mem [0:(1<<WA)-1];
      logic [7:0] q;

      always_ff @(posedge clk) begin
        if (wr_en && (byte_cnt_reg[0] == 1'(gi))) begin
          mem[wr_word] <= rxd;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          q <= rd_oob ? 8'h00 : mem[rd_word];
        end
      end
    end
  endgenerate

  assign rd_data = {lane_g[0].q, lane_g[1].q};

`ifdef FRAME_RX_STATS_EN
  logic overrun_evt;
  assign overrun_evt = (state_reg == ST_HUNT) && match_ok && frame_valid_reg && !frame_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (capture_done && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (overrun_evt && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed sequences plus randomized
// byte streams compared against a queue-based stream model.
module tb_frame_receiver;

  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        frame_ack = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  logic        frame_valid;
  logic        hunting;
  logic [15:0] rd_data;
`ifdef FRAME_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] overrun_cnt;
`endif

  frame_receiver #(.FRAME_LENGTH(FL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .hunting     (hunting),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef FRAME_RX_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stream model: history of bytes seen while hunting, payload being collected.
  logic [7:0]  magic [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
  logic [7:0]  hist [$];
  logic [7:0]  m_buf [FL];
  bit          m_known [FL];
  bit          m_cap;
  bit          m_valid;
  int          m_pay;
  int          m_frames;
  int          m_over;
  logic [15:0] m_rd;
  bit          m_rd_known;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cap = 0;
    m_valid = 0;
    m_pay = 0;
    m_frames = 0;
    m_over = 0;
    hist.delete();
    m_rd = 16'h0000;
    m_rd_known = 1;
  endfunction

  function automatic void model_edge(input logic [7:0] b, input logic ack);
    bit hit;
    if (ack) m_valid = 0;
    if (m_cap) begin
      m_buf[m_pay] = b;
      m_known[m_pay] = 1;
      m_pay++;
      if (m_pay == FL) begin
        m_cap = 0;
        m_valid = 1;
        if (m_frames < 65535) m_frames++;
        hist.delete();
      end
    end else begin
      hist.push_back(b);
      if (hist.size() > 6) void'(hist.pop_front());
      hit = (hist.size() == 6);
      for (int i = 0; i < 6 && hit; i++) if (hist[i] != magic[i]) hit = 0;
      if (hit) begin
        if (!m_valid) begin
          m_cap = 1;
          m_pay = 0;
        end else if (m_over < 65535) begin
          m_over++;
        end
      end
    end
  endfunction

  task automatic step(input logic [7:0] b, input logic ack, input logic [7:0] addr);
    int a;
    @(negedge clk);
    rxd = b;
    frame_ack = ack;
    rd_addr = addr;
    @(posedge clk);
    a = addr;
    if (a >= FL / 2) begin
      m_rd = 16'h0000;
      m_rd_known = 1;
    end else begin
      m_rd_known = m_known[2*a] && m_known[2*a+1];
      m_rd = {m_buf[2*a], m_buf[2*a+1]};
    end
    model_edge(b, ack);
    #1;
    chk("hunting", {31'b0, hunting}, {31'b0, !m_cap});
    chk("frame_valid", {31'b0, frame_valid}, {31'b0, m_valid});
    if (m_rd_known) chk("rd_data", {16'b0, rd_data}, {16'b0, m_rd});
`ifdef FRAME_RX_STATS_EN
    chk("frame_cnt", {16'b0, frame_cnt}, m_frames);
    chk("overrun_cnt", {16'b0, overrun_cnt}, m_over);
`endif
  endtask

  task automatic send_preamble(input logic ack_last);
    for (int i = 0; i < 6; i++) step(magic[i], (i == 5) && ack_last, 8'h00);
  endtask

  task automatic send_payload(input logic [7:0] base);
    for (int k = 0; k < FL; k++) step(base + 8'(k), 1'b0, 8'h00);
  endtask

  task automatic read_word(input string name, input logic [7:0] addr, input logic [15:0] exp);
    step(8'h00, 1'b0, addr);
    chk(name, {16'b0, rd_data}, {16'b0, exp});
  endtask

  initial begin
    logic [7:0] pay [FL];
    logic [7:0] b;
    logic [7:0] addr;

    for (int i = 0; i < FL; i++) m_known[i] = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_hunting", {31'b0, hunting}, 1);
    chk("rst_valid", {31'b0, frame_valid}, 0);
    chk("rst_rd_data", {16'b0, rd_data}, 0);
`ifdef FRAME_RX_STATS_EN
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 0);
    chk("rst_overrun_cnt", {16'b0, overrun_cnt}, 0);
`endif
    rst_n = 1'b1;

    // Basic frame 00..0F
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 8'h00);
    send_preamble(1'b0);
    chk("capture_hunting", {31'b0, hunting}, 0);
    for (int k = 0; k < FL - 1; k++) step(8'(k), 1'b0, 8'h00);
    chk("valid_before_last", {31'b0, frame_valid}, 0);
    step(8'h0F, 1'b0, 8'h00);
    chk("valid_after_last", {31'b0, frame_valid}, 1);
    chk("hunting_after_last", {31'b0, hunting}, 1);
`ifdef FRAME_RX_STATS_EN
    chk("frame_cnt_1", {16'b0, frame_cnt}, 1);
`endif
    rd_tab[0] = '{8'd0, 16'h0001};
    rd_tab[1] = '{8'd7, 16'h0E0F};
    rd_tab[2] = '{8'd8, 16'h0000};
    rd_tab[3] = '{8'd3, 16'h0607};
    rd_tab[4] = '{8'd255, 16'h0000};
    rd_tab[5] = '{8'd5, 16'h0A0B};
    for (int i = 0; i < 6; i++) read_word($sformatf("rd_tab%0d", i), rd_tab[i].addr, rd_tab[i].exp);

    // Payload containing the preamble at bytes 4..9
    step(8'h00, 1'b1, 8'h00);
    for (int k = 0; k < FL; k++) pay[k] = 8'h20 + 8'(k);
    for (int k = 0; k < 6; k++) pay[4+k] = magic[k];
    send_preamble(1'b0);
    for (int k = 0; k < FL; k++) step(pay[k], 1'b0, 8'h00);
    chk("embedded_valid", {31'b0, frame_valid}, 1);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0, 8'h00);
    chk("idle_hunting", {31'b0, hunting}, 1);
    read_word("embedded_w2", 8'd2, 16'hF6F6);
    read_word("embedded_w3", 8'd3, 16'hF628);
    read_word("embedded_w4", 8'd4, 16'h2828);
    read_word("embedded_w7", 8'd7, 16'h2E2F);

    // Frame while buffer full is dropped; then ack and capture another
    send_preamble(1'b0);
    chk("drop_hunting", {31'b0, hunting}, 1);
    send_payload(8'h80);
`ifdef FRAME_RX_STATS_EN
    chk("overrun_1", {16'b0, overrun_cnt}, 1);
`endif
    read_word("drop_kept_w2", 8'd2, 16'hF6F6);
    step(8'h00, 1'b1, 8'h00);
    chk("ack_clears_valid", {31'b0, frame_valid}, 0);
    send_preamble(1'b0);
    send_payload(8'h90);
    read_word("frame3_w0", 8'd0, 16'h9091);
`ifdef FRAME_RX_STATS_EN
    chk("frame_cnt_3", {16'b0, frame_cnt}, 3);
`endif

    // Ack on the same edge as a match while full: ack wins
    send_preamble(1'b1);
    chk("ackmatch_valid", {31'b0, frame_valid}, 0);
    chk("ackmatch_hunting", {31'b0, hunting}, 0);
    send_payload(8'hA0);
    chk("ackmatch_valid_rise", {31'b0, frame_valid}, 1);
`ifdef FRAME_RX_STATS_EN
    chk("ackmatch_overrun", {16'b0, overrun_cnt}, 1);
`endif
    read_word("ackmatch_w1", 8'd1, 16'hA2A3);

    // Reset mid-capture
    step(8'h00, 1'b1, 8'h00);
    send_preamble(1'b0);
    for (int k = 0; k < 5; k++) step(8'hB0 + 8'(k), 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hunting", {31'b0, hunting}, 1);
    chk("midrst_valid", {31'b0, frame_valid}, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_preamble(1'b0);
    send_payload(8'hC0);
    chk("post_rst_valid", {31'b0, frame_valid}, 1);
    read_word("post_rst_w7", 8'd7, 16'hCECF);

    // Partial preamble followed by a full one
    step(8'h00, 1'b1, 8'h00);
    step(8'hF6, 1'b0, 8'h00);
    step(8'hF6, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(8'h28, 1'b0, 8'h00);
    chk("partial_hunting", {31'b0, hunting}, 1);
    send_preamble(1'b0);
    send_payload(8'h40);
    read_word("aligned_w0", 8'd0, 16'h4041);
    read_word("aligned_w6", 8'd6, 16'h4C4D);

    // Randomized streams against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_preamble($urandom_range(0, 3) == 0);
      end else begin
        case ($urandom_range(0, 3))
          0: b = 8'hF6;
          1: b = 8'h28;
          default: b = 8'($urandom);
        endcase
        addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
        step(b, $urandom_range(0, 15) == 0, addr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
